// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: word/line types, cache line geometry and
// the pmem scheduler state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_pmem_data;

  localparam int unsigned LINE_OFFSET_BITS = 4;
  localparam int unsigned LINE_TAG_BITS    = 16 - LINE_OFFSET_BITS;

  typedef logic [LINE_TAG_BITS-1:0] lc3b_line_tag;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    RESP
  } pmem_sched_state_t;

  function automatic lc3b_line_tag line_tag(input lc3b_word addr);
    return addr[15:LINE_OFFSET_BITS];
  endfunction

endpackage

// File: rtl/pmem_wbuf.sv
// Single-entry write buffer for pmem_scheduler: holds one evicted line and
// reports whether a lookup line tag hits it.
module pmem_wbuf
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          capture,
  input  logic          clear,
  input  lc3b_word      cap_address,
  input  lc3b_pmem_data cap_data,
  input  lc3b_line_tag  lookup_tag,
  output logic          valid,
  output lc3b_word      address,
  output lc3b_pmem_data data,
  output logic          hit
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid   <= 1'b0;
      address <= '0;
      data    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid   <= 1'b1;
      address <= cap_address;
      data    <= cap_data;
    end
  end

  assign hit = valid && (lookup_tag == line_tag(address));

endmodule

// File: rtl/pmem_scheduler.sv
// Arbitrates L2 line reads/write-backs onto physical memory through a
// one-entry write buffer. Define PMEM_SCHED_FWD_EN to forward read hits.
module pmem_scheduler
  import lc3b_types::*;
#(
  parameter int unsigned DRAIN_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          l2_read,
  input  logic          l2_write,
  input  lc3b_word      l2_address,
  input  lc3b_pmem_data l2_wdata,
  output logic          l2_resp,
  output lc3b_pmem_data l2_rdata,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_pmem_data pmem_wdata,
  input  logic          pmem_resp,
  input  lc3b_pmem_data pmem_rdata,
  output logic          wb_valid
);

`ifdef PMEM_SCHED_FWD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  localparam int unsigned CNT_W = (DRAIN_LIMIT < 1) ? 1 : $clog2(DRAIN_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DRAIN_LIMIT);

  pmem_sched_state_t state, state_next;
  logic [CNT_W-1:0]  defer_cnt, defer_next;

  logic          wb_capture, wb_clear, wb_hit, fwd_load;
  lc3b_word      wb_address;
  lc3b_pmem_data wb_data;
  logic          rd_req, wr_req;

  pmem_wbuf u_wbuf (
    .clk         (clk),
    .reset_n     (reset_n),
    .capture     (wb_capture),
    .clear       (wb_clear),
    .cap_address (l2_address),
    .cap_data    (l2_wdata),
    .lookup_tag  (line_tag(l2_address)),
    .valid       (wb_valid),
    .address     (wb_address),
    .data        (wb_data),
    .hit         (wb_hit)
  );

  // A simultaneous read and write is serviced as a read.
  assign rd_req = l2_read;
  assign wr_req = l2_write && !l2_read;

  always_comb begin
    state_next = state;
    defer_next = defer_cnt;
    wb_capture = 1'b0;
    wb_clear   = 1'b0;
    fwd_load   = 1'b0;
    unique case (state)
      IDLE: begin
        if (wb_valid && (wr_req || (defer_cnt == CNT_MAX) ||
                         (rd_req && wb_hit && !FWD_EN))) begin
          state_next = DRAIN;
        end else if (rd_req && wb_hit && FWD_EN) begin
          fwd_load   = 1'b1;
          state_next = RESP;
        end else if (rd_req) begin
          state_next = READ;
          if (wb_valid && (defer_cnt != CNT_MAX)) defer_next = defer_cnt + 1'b1;
        end else if (wr_req) begin
          // Buffer must be empty here: a valid buffer with a write drained above.
          wb_capture = 1'b1;
          state_next = RESP;
        end else if (wb_valid) begin
          state_next = DRAIN;
        end
      end
      READ: begin
        if (pmem_resp) state_next = RESP;
      end
      DRAIN: begin
        if (pmem_resp) begin
          wb_clear   = 1'b1;
          defer_next = '0;
          state_next = IDLE;
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes and addresses are registered from the next state so they line up
  // with the state that owns them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      defer_cnt    <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      l2_resp      <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      l2_rdata     <= '0;
    end else begin
      state        <= state_next;
      defer_cnt    <= defer_next;
      pmem_read    <= (state_next == READ);
      pmem_write   <= (state_next == DRAIN);
      l2_resp      <= (state_next == RESP);
      pmem_address <= (state_next == READ)  ? l2_address :
                      (state_next == DRAIN) ? wb_address : '0;
      pmem_wdata   <= (state_next == DRAIN) ? wb_data : '0;
      if ((state == READ) && pmem_resp) begin
        l2_rdata <= pmem_rdata;
      end else if (fwd_load) begin
        l2_rdata <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_pmem_scheduler.sv
// Directed bench for pmem_scheduler with a latency-2 physical memory model
// that logs every completed pmem transaction.
module tb_pmem_scheduler;
  import lc3b_types::*;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          l2_read, l2_write;
  lc3b_word      l2_address;
  lc3b_pmem_data l2_wdata;
  logic          l2_resp;
  lc3b_pmem_data l2_rdata;
  logic          pmem_read, pmem_write;
  lc3b_word      pmem_address;
  lc3b_pmem_data pmem_wdata;
  logic          pmem_resp;
  lc3b_pmem_data pmem_rdata;
  logic          wb_valid;

  always #5 clk = ~clk;

  pmem_scheduler #(.DRAIN_LIMIT(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .l2_read      (l2_read),
    .l2_write     (l2_write),
    .l2_address   (l2_address),
    .l2_wdata     (l2_wdata),
    .l2_resp      (l2_resp),
    .l2_rdata     (l2_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata),
    .wb_valid     (wb_valid)
  );

  localparam int MEM_LAT = 2;
  localparam lc3b_pmem_data D1 = {8{16'hD1D1}};
  localparam lc3b_pmem_data D2 = {8{16'hD2E2}};
  localparam lc3b_pmem_data D3 = {8{16'hD3F3}};
  localparam lc3b_pmem_data D4 = {8{16'hD404}};
  localparam lc3b_pmem_data D5 = {8{16'hD515}};
  localparam lc3b_pmem_data D6 = {8{16'hD626}};
  localparam lc3b_pmem_data D7 = {8{16'hD737}};

  int checks = 0;
  int errors = 0;

  lc3b_pmem_data mem [lc3b_line_tag];
  int            log_n = 0;
  logic          log_wr   [32];
  lc3b_word      log_addr [32];
  lc3b_pmem_data log_data [32];
  int            both_cnt = 0;
  int            rd_cycles = 0;

  function automatic lc3b_pmem_data init_line(input lc3b_word a);
    lc3b_word la;
    la = {a[15:4], 4'h0};
    return {8{la ^ 16'h5A5A}};
  endfunction

  // Physical memory: responds MEM_LAT cycles after a strobe is seen.
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n || pmem_resp) begin
        pmem_resp = 1'b0;
        wait_cnt  = 0;
      end else if (pmem_read || pmem_write) begin
        if (wait_cnt == MEM_LAT) begin
          if (log_n < 32) begin
            log_wr[log_n]   = pmem_write;
            log_addr[log_n] = pmem_address;
            log_data[log_n] = pmem_wdata;
            log_n++;
          end
          if (pmem_write) mem[line_tag(pmem_address)] = pmem_wdata;
          else if (mem.exists(line_tag(pmem_address))) pmem_rdata = mem[line_tag(pmem_address)];
          else pmem_rdata = init_line(pmem_address);
          pmem_resp = 1'b1;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (pmem_read && pmem_write) both_cnt++;
    if (pmem_read) rd_cycles++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // lat = rising edge at which the requester samples l2_resp=1.
  task automatic do_req(input logic rd, input logic wr, input lc3b_word a,
                        input lc3b_pmem_data d, output logic got,
                        output lc3b_pmem_data rdata, output int lat);
    l2_read = rd; l2_write = wr; l2_address = a; l2_wdata = d;
    got = 1'b0; rdata = '0; lat = 0;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(posedge clk); #1;
      if (l2_resp) begin
        got = 1'b1; rdata = l2_rdata; lat = i + 1;
      end
    end
    l2_read = 1'b0; l2_write = 1'b0;
  endtask

  task automatic wait_empty(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk); #1;
      if (!wb_valid && !pmem_write) ok = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; l2_read = 1'b0; l2_write = 1'b0;
    l2_address = '0; l2_wdata = '0;
    repeat (3) @(posedge clk); #1;
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL rst_pmem_read got %b exp 0", pmem_read); end
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL rst_pmem_write got %b exp 0", pmem_write); end
    checks++; if (l2_resp !== 1'b0) begin errors++; $display("FAIL rst_l2_resp got %b exp 0", l2_resp); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got %b exp 0", wb_valid); end
    checks++; if (pmem_address !== 16'h0) begin errors++; $display("FAIL rst_pmem_address got %h exp 0", pmem_address); end
    checks++; if (l2_rdata !== '0) begin errors++; $display("FAIL rst_l2_rdata got %h exp 0", l2_rdata); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_capture;
    logic got, ok; lc3b_pmem_data rd; int lat, base;
    base = log_n;
    do_req(1'b0, 1'b1, 16'h1230, D1, got, rd, lat);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL wr_resp got %b exp 1", got); end
    checks++; if (lat != 2) begin errors++; $display("FAIL wr_latency got %0d exp 2", lat); end
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL wr_wb_valid got %b exp 1", wb_valid); end
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL wr_no_pmem_write got %b exp 0", pmem_write); end
    checks++; if (log_n != base) begin errors++; $display("FAIL wr_no_pmem_txn got %0d exp %0d", log_n, base); end
    wait_empty(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wr_drain_done got %b exp 1", ok); end
    checks++; if (log_n != base + 1) begin errors++; $display("FAIL wr_drain_count got %0d exp %0d", log_n, base + 1); end
    checks++; if (log_wr[base] !== 1'b1 || log_addr[base] !== 16'h1230 || log_data[base] !== D1) begin
      errors++; $display("FAIL wr_drain_txn got w=%b a=%h d=%h exp w=1 a=1230 d=%h",
                         log_wr[base], log_addr[base], log_data[base], D1);
    end
  endtask

  task automatic test_forward;
    logic got, ok; lc3b_pmem_data rd; int lat, base, rd0;
    base = log_n;
    rd0  = rd_cycles;
    do_req(1'b0, 1'b1, 16'h1230, D2, got, rd, lat);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL fwd_wr_resp got %b exp 1", got); end
    do_req(1'b1, 1'b0, 16'h1238, '0, got, rd, lat);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL fwd_rd_resp got %b exp 1", got); end
    checks++; if (rd !== D2) begin errors++; $display("FAIL fwd_rdata got %h exp %h", rd, D2); end
`ifdef PMEM_SCHED_FWD_EN
    checks++; if (log_n != base) begin errors++; $display("FAIL fwd_no_pmem got %0d exp %0d", log_n, base); end
    checks++; if (rd_cycles != rd0) begin errors++; $display("FAIL fwd_no_pmem_read got %0d exp %0d", rd_cycles, rd0); end
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL fwd_wb_kept got %b exp 1", wb_valid); end
`else
    checks++; if (log_n != base + 2) begin errors++; $display("FAIL nofwd_count got %0d exp %0d", log_n, base + 2); end
    checks++; if (log_wr[base] !== 1'b1 || log_addr[base] !== 16'h1230) begin
      errors++; $display("FAIL nofwd_drain_first got w=%b a=%h exp w=1 a=1230", log_wr[base], log_addr[base]);
    end
    checks++; if (log_wr[base+1] !== 1'b0 || log_addr[base+1] !== 16'h1238) begin
      errors++; $display("FAIL nofwd_read_second got w=%b a=%h exp w=0 a=1238", log_wr[base+1], log_addr[base+1]);
    end
    checks++; if (rd_cycles == rd0) begin errors++; $display("FAIL nofwd_pmem_read got %0d exp >%0d", rd_cycles, rd0); end
`endif
    wait_empty(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fwd_empty got %b exp 1", ok); end
  endtask

  task automatic test_defer;
    logic got, ok; lc3b_pmem_data rd; int lat, base;
    lc3b_word rd_addr [5];
    logic     exp_wr [6];
    lc3b_word exp_addr [6];
    rd_addr  = '{16'h2000, 16'h3000, 16'h5000, 16'h6000, 16'h7000};
    exp_wr   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_addr = '{16'h2000, 16'h3000, 16'h5000, 16'h6000, 16'h1230, 16'h7000};
    base = log_n;
    do_req(1'b0, 1'b1, 16'h1230, D3, got, rd, lat);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL defer_wr_resp got %b exp 1", got); end
    for (int i = 0; i < 5; i++) begin
      do_req(1'b1, 1'b0, rd_addr[i], '0, got, rd, lat);
      checks++; if (got !== 1'b1 || rd !== init_line(rd_addr[i])) begin
        errors++; $display("FAIL defer_read%0d got r=%b d=%h exp r=1 d=%h", i, got, rd, init_line(rd_addr[i]));
      end
    end
    checks++; if (log_n != base + 6) begin errors++; $display("FAIL defer_count got %0d exp %0d", log_n, base + 6); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (log_wr[base+i] !== exp_wr[i] || log_addr[base+i] !== exp_addr[i]) begin
        errors++; $display("FAIL defer_order%0d got w=%b a=%h exp w=%b a=%h",
                           i, log_wr[base+i], log_addr[base+i], exp_wr[i], exp_addr[i]);
      end
    end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL defer_wb_empty got %b exp 0", wb_valid); end
    wait_empty(ok);
  endtask

  task automatic test_write_drain;
    logic got, ok; lc3b_pmem_data rd; int lat, base;
    base = log_n;
    do_req(1'b0, 1'b1, 16'h1230, D4, got, rd, lat);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL wd_first_resp got %b exp 1", got); end
    do_req(1'b0, 1'b1, 16'h4000, D5, got, rd, lat);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL wd_second_resp got %b exp 1", got); end
    checks++; if (log_n != base + 1 || log_wr[base] !== 1'b1 || log_addr[base] !== 16'h1230 || log_data[base] !== D4) begin
      errors++; $display("FAIL wd_drain_first got n=%0d a=%h d=%h exp n=%0d a=1230 d=%h",
                         log_n - base, log_addr[base], log_data[base], 1, D4);
    end
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL wd_captured got %b exp 1", wb_valid); end
    wait_empty(ok);
    checks++; if (log_n != base + 2 || log_addr[base+1] !== 16'h4000 || log_data[base+1] !== D5) begin
      errors++; $display("FAIL wd_drain_second got n=%0d a=%h d=%h exp n=2 a=4000 d=%h",
                         log_n - base, log_addr[base+1], log_data[base+1], D5);
    end
  endtask

  task automatic test_simultaneous;
    logic got; lc3b_pmem_data rd; int lat, base;
    base = log_n;
    do_req(1'b1, 1'b1, 16'h5000, D6, got, rd, lat);
    checks++; if (got !== 1'b1 || rd !== init_line(16'h5000)) begin
      errors++; $display("FAIL simul_read got r=%b d=%h exp r=1 d=%h", got, rd, init_line(16'h5000));
    end
    checks++; if (log_n != base + 1 || log_wr[base] !== 1'b0) begin
      errors++; $display("FAIL simul_txn got n=%0d w=%b exp n=1 w=0", log_n - base, log_wr[base]);
    end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL simul_no_capture got %b exp 0", wb_valid); end
  endtask

  task automatic test_reset_midread;
    logic got, seen; lc3b_pmem_data rd; int lat;
    do_req(1'b0, 1'b1, 16'h1230, D7, got, rd, lat);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL mid_wr_resp got %b exp 1", got); end
    l2_read = 1'b1; l2_address = 16'h6000;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (pmem_read) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mid_read_started got %b exp 1", seen); end
    reset_n = 1'b0;
    #1;
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL mid_pmem_read got %b exp 0", pmem_read); end
    checks++; if (l2_resp !== 1'b0) begin errors++; $display("FAIL mid_l2_resp got %b exp 0", l2_resp); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL mid_wb_valid got %b exp 0", wb_valid); end
    l2_read = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL mid_after_reset got r=%b w=%b v=%b exp 0 0 0", pmem_read, pmem_write, wb_valid);
    end
  endtask

  task automatic test_strobe_exclusive;
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL strobe_exclusive got %0d exp 0", both_cnt); end
  endtask

  initial begin
    test_reset;
    test_write_capture;
    test_forward;
    test_defer;
    test_write_drain;
    test_simultaneous;
    test_reset_midread;
    test_strobe_exclusive;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
